// File: rtl/bit_unpack_if.sv
`default_nettype none
// ============================================================================
// Module      : bit_unpack_if
// Description : Handshake bundle for the bit_unpack mask decoder. It carries
//               the mask-in handshake, the index-out handshake and the status
//               strobes.
//                 in_valid / in_ready / in_mask   : mask input handshake
//                 out_valid / out_ready           : index output handshake
//                 out_index / out_last            : decoded index, last flag
//                 done / busy                     : status
//               slave  : the decoder side
//               master : the producer/consumer side that drives the decoder
// Revision    : 1.0 - initial release
// ============================================================================
interface bit_unpack_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic             done;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_mask,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_index,
        output out_last,
        output done,
        output busy
    );

    modport master (
        output in_valid,
        output in_mask,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_index,
        input  out_last,
        input  done,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/bit_unpack.sv
`default_nettype none
// ============================================================================
// Module      : bit_unpack
// Description : Sequential decoder for an OR-merged request/flag vector.
//               Accepts a WIDTH-bit mask and emits the index of each set bit,
//               lowest first, one per output handshake.
// Ports       : clock    - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               bus      - bit_unpack_if.slave
//                          in_valid/in_ready/in_mask : mask input
//                          out_valid/out_ready       : index handshake
//                          out_index/out_last        : lowest remaining bit
//                          done  : one-cycle pulse once a mask is decoded
//                          busy  : high while emitting indices
// Revision    : 1.0 - initial release
// ============================================================================
module bit_unpack #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  wire logic       clock,
    input  wire logic       reset_n,
    bit_unpack_if.slave     bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_rem;
    logic             r_done;

    logic [WIDTH-1:0] w_rem_next;
    logic [IDXW-1:0]  w_index;
    logic             w_accept;
    logic             w_pop;
    logic             w_emit;

    assign w_emit = (r_state == S_EMIT);

    // Clearing the lowest set bit: x & (x-1). When the result is zero the
    // bit being presented is the only one left, which is exactly out_last.
    assign w_rem_next = r_rem & (r_rem - WIDTH'(1));

    // Lowest set bit of the remaining mask. Scanning downward lets the
    // lowest hit win; an all-zero remainder (idle) yields index 0.
    always_comb begin
        w_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_rem[i]) begin
                w_index = IDXW'(i);
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_pop    = w_emit && bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.in_mask != '0) begin
                            r_rem   <= bus.in_mask;
                            r_state <= S_EMIT;
                        end else begin
                            // Empty mask: nothing to emit, just report done.
                            r_done <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_pop) begin
                        r_rem <= w_rem_next;
                        if (w_rem_next == '0) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready is forced low while reset is held so no mask can be offered
    // into a block that is being cleared.
    assign bus.in_ready  = (r_state == S_IDLE) && reset_n;
    assign bus.out_valid = w_emit;
    assign bus.busy      = w_emit;
    assign bus.out_index = w_index;
    assign bus.out_last  = w_emit && (w_rem_next == '0);
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bit_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_unpack
// Description : Self-checking bench for bit_unpack. A reference queue of the
//               set-bit positions of each mask is built by scanning the mask,
//               and every beat is compared against its head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_unpack;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   busy_cycles;

    bit_unpack_if #(.WIDTH(32), .IDXW(5)) bus ();

    bit_unpack #(.WIDTH(32), .IDXW(5)) u_dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: consumer always ready; 1: random ready; 2: stalled 3 cycles
    task automatic send_mask(input logic [31:0] mask, input int mode);
        int q[$];
        int cyc;
        int wait_n;
        logic r;
        for (int b = 0; b < 32; b++) begin
            if (mask[b]) q.push_back(b);
        end

        wait_n = 0;
        while (!bus.in_ready && wait_n < 100) begin
            tick();
            wait_n++;
        end
        check("in_ready_idle", bus.in_ready, 1);

        bus.in_valid  = 1'b1;
        bus.in_mask   = mask;
        bus.out_ready = (mode == 0);
        tick();
        bus.in_valid  = 1'b0;
        bus.in_mask   = $urandom;
        busy_cycles   = 0;
        cyc           = 0;

        if (q.size() == 0) begin
            check("zero_done", bus.done, 1);
            check("zero_out_valid", bus.out_valid, 0);
            check("zero_in_ready", bus.in_ready, 1);
            check("zero_busy", bus.busy, 0);
            tick();
            check("zero_done_pulse", bus.done, 0);
            check("zero_out_valid2", bus.out_valid, 0);
        end else begin
            while (q.size() > 0 && cyc < 200) begin
                check("emit_valid", bus.out_valid, 1);
                check("emit_in_ready", bus.in_ready, 0);
                check("emit_done", bus.done, 0);
                check("emit_index", bus.out_index, q[0]);
                check("emit_last", bus.out_last, (q.size() == 1));
                if (bus.busy) busy_cycles++;
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (cyc >= 3);
                endcase
                bus.out_ready = r;
                // Offers during EMIT must be ignored by the decoder.
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.in_mask   = $urandom;
                tick();
                if (r) void'(q.pop_front());
                cyc++;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            check("drained", q.size(), 0);
            check("end_done", bus.done, 1);
            check("end_out_valid", bus.out_valid, 0);
            check("end_in_ready", bus.in_ready, 1);
            check("end_busy", bus.busy, 0);
        end
    endtask

    initial begin
        logic [31:0] m;
        n_checks      = 0;
        n_errors      = 0;
        busy_cycles   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_index", bus.out_index, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // Directed cases
        send_mask(32'h0000_0001, 0);
        send_mask(32'h8000_0011, 0);
        check("three_beats_busy", busy_cycles, 3);
        send_mask(32'h0000_0006, 2);
        send_mask(32'h0000_0000, 0);
        send_mask(32'hFFFF_FFFF, 0);
        check("full_busy_cycles", busy_cycles, 32);

        // Asynchronous reset in the middle of a decode
        tick();
        bus.in_valid  = 1'b1;
        bus.in_mask   = 32'h0000_00F0;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        check("mid_idx4", bus.out_index, 4);
        tick();
        check("mid_idx5", bus.out_index, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_in_ready", bus.in_ready, 0);
        check("async_busy", bus.busy, 0);
        check("async_index", bus.out_index, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_valid", bus.out_valid, 0);
        end
        bus.out_ready = 1'b0;
        send_mask(32'h0000_0002, 0);
        check("single_busy", busy_cycles, 1);

        // Randomized masks with random backpressure
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       m = $urandom;
                1:       m = $urandom & $urandom & $urandom;
                2:       m = 32'h1 << $urandom_range(0, 31);
                default: m = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h8000_0000);
            endcase
            send_mask(m, $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
